// File: rtl/alu_arb_if.sv
// Bundle of the two requester channels, the ALU drive/result pair and the response
// channel. The slave modport is the arbiter's view; master is the client/ALU side.
interface alu_arb_if;
  logic       v0;
  logic       r0;
  logic [3:0] s0;
  logic [3:0] a0;
  logic [3:0] b0;
  logic       v1;
  logic       r1;
  logic [3:0] s1;
  logic [3:0] a1;
  logic [3:0] b1;
  logic [3:0] alu_s;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [7:0] alu_y;
  logic       vld;
  logic       rdy;
  logic [7:0] y;
  logic       id;
  logic       err;
  logic [7:0] cnt;

  modport slave (
    input  v0, s0, a0, b0, v1, s1, a1, b1, alu_y, rdy,
    output r0, r1, alu_s, alu_a, alu_b, vld, y, id, err, cnt
  );

  modport master (
    output v0, s0, a0, b0, v1, s1, a1, b1, alu_y, rdy,
    input  r0, r1, alu_s, alu_a, alu_b, vld, y, id, err, cnt
  );
endinterface

// File: rtl/alu_arb.sv
// Round-robin arbiter/sequencer for two clients sharing one external combinational ALU.
// Accept -> capture -> respond, with divide/modulo-by-zero screening on capture.
module alu_arb (
  input  logic     clk,
  input  logic     rst,
  alu_arb_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e     state_q, state_d;
  logic       last_q, last_d;
  logic [3:0] alu_s_q, alu_s_d;
  logic [3:0] alu_a_q, alu_a_d;
  logic [3:0] alu_b_q, alu_b_d;
  logic [7:0] y_q, y_d;
  logic       id_q, id_d;
  logic       err_q, err_d;
  logic [7:0] cnt_q, cnt_d;

  logic gnt0, gnt1, div_zero;

  // last_q names the previous grantee; on a tie the other requester wins.
  assign gnt0     = bus.v0 & (~bus.v1 | last_q);
  assign gnt1     = bus.v1 & (~bus.v0 | ~last_q);
  assign div_zero = ((alu_s_q == 4'b0011) || (alu_s_q == 4'b0100)) && (alu_b_q == 4'd0);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    alu_s_d = alu_s_q;
    alu_a_d = alu_a_q;
    alu_b_d = alu_b_q;
    y_d     = y_q;
    id_d    = id_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (gnt0) begin
          alu_s_d = bus.s0;
          alu_a_d = bus.a0;
          alu_b_d = bus.b0;
          id_d    = 1'b0;
          last_d  = 1'b0;
          state_d = StExec;
        end else if (gnt1) begin
          alu_s_d = bus.s1;
          alu_a_d = bus.a1;
          alu_b_d = bus.b1;
          id_d    = 1'b1;
          last_d  = 1'b1;
          state_d = StExec;
        end
      end
      StExec: begin
        y_d     = div_zero ? 8'hFF : bus.alu_y;
        err_d   = div_zero;
        state_d = StResp;
      end
      StResp: begin
        if (bus.rdy) begin
          cnt_d   = cnt_q + 8'd1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      alu_s_q <= 4'd0;
      alu_a_q <= 4'd0;
      alu_b_q <= 4'd0;
      y_q     <= 8'd0;
      id_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      alu_s_q <= alu_s_d;
      alu_a_q <= alu_a_d;
      alu_b_q <= alu_b_d;
      y_q     <= y_d;
      id_q    <= id_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Ready is suppressed during reset even though state already reads idle.
  assign bus.r0    = (state_q == StIdle) & gnt0 & ~rst;
  assign bus.r1    = (state_q == StIdle) & gnt1 & ~rst;
  assign bus.vld   = (state_q == StResp);
  assign bus.alu_s = alu_s_q;
  assign bus.alu_a = alu_a_q;
  assign bus.alu_b = alu_b_q;
  assign bus.y     = y_q;
  assign bus.id    = id_q;
  assign bus.err   = err_q;
  assign bus.cnt   = cnt_q;

endmodule

// File: tb/tb_alu_arb.sv
// Directed bench for alu_arb: vector table of single ops plus tie, backpressure,
// mid-op reset and counter-wrap sequences. A small ALU model sits beside the DUT.
module tb_alu_arb;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  alu_arb_if bus ();

  alu_arb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // External ALU; divide/modulo by zero deliberately return 0 so the override shows.
  function automatic logic [7:0] alu_model(input logic [3:0] s, input logic [3:0] a,
                                           input logic [3:0] b);
    case (s)
      4'd0:    return {4'd0, a} + {4'd0, b};
      4'd1:    return {4'd0, a} - {4'd0, b};
      4'd2:    return {4'd0, a} * {4'd0, b};
      4'd3:    return (b == 4'd0) ? 8'h00 : {4'd0, a / b};
      4'd4:    return (b == 4'd0) ? 8'h00 : {4'd0, a % b};
      4'd14:   return {a, b};
      default: return {4'd0, a & b};
    endcase
  endfunction

  assign bus.alu_y = alu_model(bus.alu_s, bus.alu_a, bus.alu_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.v0 = 0; bus.s0 = 0; bus.a0 = 0; bus.b0 = 0;
    bus.v1 = 0; bus.s1 = 0; bus.a1 = 0; bus.b1 = 0;
    bus.rdy = 1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
    tick();
  endtask

  // Present one request, wait (bounded) for its ready, then let it be accepted.
  task automatic issue(input bit req, input logic [3:0] s, input logic [3:0] a,
                       input logic [3:0] b);
    int k;
    if (req) begin bus.s1 = s; bus.a1 = a; bus.b1 = b; bus.v1 = 1; end
    else     begin bus.s0 = s; bus.a0 = a; bus.b0 = b; bus.v0 = 1; end
    #1;
    k = 0;
    while (!(req ? bus.r1 : bus.r0) && k < 20) begin
      tick();
      k++;
    end
    check("grant", {31'd0, req ? bus.r1 : bus.r0}, 32'd1);
    tick();
    bus.v0 = 0;
    bus.v1 = 0;
  endtask

  typedef struct {
    bit         req;
    logic [3:0] s;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] y;
    bit         err;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int k;
    int bad;
    logic [7:0] y_hold;
    n_checks = 0;
    n_errors = 0;

    vecs[0] = '{0, 4'd0,  4'd9,  4'd7,  8'h10, 0};
    vecs[1] = '{1, 4'd1,  4'd8,  4'd3,  8'h05, 0};
    vecs[2] = '{0, 4'd2,  4'd3,  4'd5,  8'h0F, 0};
    vecs[3] = '{1, 4'd3,  4'd6,  4'd0,  8'hFF, 1};
    vecs[4] = '{1, 4'd4,  4'd7,  4'd3,  8'h01, 0};
    vecs[5] = '{0, 4'd3,  4'd13, 4'd4,  8'h03, 0};
    vecs[6] = '{0, 4'd4,  4'd5,  4'd0,  8'hFF, 1};
    vecs[7] = '{1, 4'd14, 4'd2,  4'd5,  8'h25, 0};
    vecs[8] = '{0, 4'd1,  4'd3,  4'd8,  8'hFB, 0};
    vecs[9] = '{1, 4'd2,  4'd15, 4'd15, 8'hE1, 0};

    // Reset state, with v0 high to show ready is held low during reset.
    clear_inputs();
    rst = 1;
    bus.v0 = 1;
    #3;
    check("rst_r0", {31'd0, bus.r0}, 32'd0);
    check("rst_vld", {31'd0, bus.vld}, 32'd0);
    check("rst_cnt", {24'd0, bus.cnt}, 32'd0);
    check("rst_y", {24'd0, bus.y}, 32'd0);
    check("rst_id_err", {30'd0, bus.id, bus.err}, 32'd0);
    check("rst_alu", {20'd0, bus.alu_s, bus.alu_a, bus.alu_b}, 32'd0);
    tick();
    bus.v0 = 0;
    rst = 0;
    tick();

    // Table of single operations, rdy held high.
    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].req, vecs[i].s, vecs[i].a, vecs[i].b);
      check("exec_vld_low", {31'd0, bus.vld}, 32'd0);
      tick();
      check("resp_vld", {31'd0, bus.vld}, 32'd1);
      check("resp_y", {24'd0, bus.y}, {24'd0, vecs[i].y});
      check("resp_id", {31'd0, bus.id}, {31'd0, vecs[i].req});
      check("resp_err", {31'd0, bus.err}, {31'd0, vecs[i].err});
      tick();
      check("done_vld_low", {31'd0, bus.vld}, 32'd0);
      check("cnt", {24'd0, bus.cnt}, i + 1);
    end

    // Tie: both valid continuously, grants must alternate starting at 0.
    do_reset();
    bus.s0 = 4'd2; bus.a0 = 4'd3; bus.b0 = 4'd5;
    bus.s1 = 4'd1; bus.a1 = 4'd8; bus.b1 = 4'd3;
    bus.v0 = 1; bus.v1 = 1;
    #1;
    for (int j = 0; j < 4; j++) begin
      k = 0;
      while (!(bus.r0 || bus.r1) && k < 10) begin
        tick();
        k++;
      end
      check("tie_grant", {30'd0, bus.r1, bus.r0}, (j % 2) ? 32'd2 : 32'd1);
      tick();
      tick();
      check("tie_vld", {31'd0, bus.vld}, 32'd1);
      check("tie_y", {24'd0, bus.y}, (j % 2) ? 32'd5 : 32'd15);
      check("tie_id", {31'd0, bus.id}, j % 2);
      tick();
    end
    clear_inputs();

    // Backpressure: response held for 5 cycles while requester 0 keeps asking.
    do_reset();
    issue(0, 4'd0, 4'd4, 4'd4);
    bus.rdy = 0;
    tick();
    bus.s0 = 4'd2; bus.a0 = 4'd2; bus.b0 = 4'd3; bus.v0 = 1;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (!bus.vld || bus.y != 8'h08 || bus.id || bus.err || bus.r0 || bus.r1) bad++;
      tick();
    end
    check("bp_stable", bad, 0);
    check("bp_cnt_held", {24'd0, bus.cnt}, 32'd0);
    bus.rdy = 1;
    tick();
    check("bp_release_vld", {31'd0, bus.vld}, 32'd0);
    check("bp_next_r0", {31'd0, bus.r0}, 32'd1);
    check("bp_cnt", {24'd0, bus.cnt}, 32'd1);
    tick();
    bus.v0 = 0;
    tick();
    check("bp_second_y", {24'd0, bus.y}, 32'd6);
    tick();

    // Reset while in EXEC: nothing emitted, counter untouched.
    do_reset();
    bus.v0 = 1; bus.s0 = 4'd0; bus.a0 = 4'd1; bus.b0 = 4'd1;
    tick();
    rst = 1;
    #1;
    check("mid_rst_vld", {31'd0, bus.vld}, 32'd0);
    check("mid_rst_alu", {20'd0, bus.alu_s, bus.alu_a, bus.alu_b}, 32'd0);
    check("mid_rst_r0", {31'd0, bus.r0}, 32'd0);
    bus.v0 = 0;
    tick();
    rst = 0;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (bus.vld) bad++;
    end
    check("mid_rst_no_resp", bad, 0);
    check("mid_rst_cnt", {24'd0, bus.cnt}, 32'd0);

    // Counter wrap over 256 completed operations.
    do_reset();
    bus.s0 = 4'd14; bus.a0 = 4'd2; bus.b0 = 4'd5; bus.v0 = 1;
    bad = 0;
    for (int n = 0; n < 256; n++) begin
      k = 0;
      while (!bus.vld && k < 10) begin
        tick();
        k++;
      end
      if (!bus.vld || bus.y != 8'h25) bad++;
      if (n == 255) check("wrap_cnt_255", {24'd0, bus.cnt}, 32'd255);
      y_hold = bus.y;
      tick();
    end
    bus.v0 = 0;
    check("wrap_y", bad, 0);
    check("wrap_last_y", {24'd0, y_hold}, 32'h25);
    check("wrap_cnt_0", {24'd0, bus.cnt}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Hard stop in case a sequence stalls beyond its bounded waits.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
